divide_result_buffer: RTL and testbench

//  Downstream stage of the 40/8 fixed-point divider. Captures the divider's result

---
 rtl/divide_result_buffer_if.sv | 31 +++
 rtl/divide_result_buffer.sv | 142 ++++++++++++++
 tb/tb_divide_result_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/divide_result_buffer_if.sv
// divide_result_buffer_if
//   Stream bundle around the divider result buffer.
//   - s_axis_result_*: divider result stream (no tready, cannot be stalled).
//   - m_axis_*: buffered, rounded quotient stream toward a back-pressurable consumer.
//   Modports:
//   - slave: the buffer's view (consumes results, produces m_axis).
//   - master: the environment's view (produces results, consumes m_axis).
interface divide_result_buffer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  logic              s_axis_result_tvalid;
  logic [IN_W-1:0]   s_axis_result_tdata;
  logic              s_axis_result_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [OUT_W-1:0]  m_axis_tdata;
  logic [1:0]        m_axis_tuser;

  modport slave (
    input  s_axis_result_tvalid, s_axis_result_tdata, s_axis_result_tuser,
    input  m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser
  );

  modport master (
    output s_axis_result_tvalid, s_axis_result_tdata, s_axis_result_tuser,
    output m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser
  );
endinterface

// File: rtl/divide_result_buffer.sv
// divide_result_buffer
//   Downstream stage of the fixed-point divider. Rounds (half toward +inf) and
//   saturates the Q(INT_W).(FRAC_W) quotient to a signed Q(OUT_W-OUT_FRAC).OUT_FRAC
//   word, buffers it in a show-ahead FIFO, and tracks credits so the divider only
//   launches a divide when its result is guaranteed a FIFO slot.
// Ports:
//   aclk, areset  clock / asynchronous active-high reset
//   issue         pulse: divider accepted a new operand pair
//   issue_ok      a new issue is allowed this cycle
//   axis          result input stream and buffered output stream (slave modport)
//   overflow_cnt  results dropped on a full FIFO, saturating at 0xFFFF
module divide_result_buffer #(
  parameter int INT_W    = 40,
  parameter int FRAC_W   = 24,
  parameter int OUT_W    = 32,
  parameter int OUT_FRAC = 16,
  parameter int DEPTH    = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    issue,
  output logic                    issue_ok,
  divide_result_buffer_if.slave   axis,
  output logic [15:0]             overflow_cnt
);

  localparam int IN_W  = INT_W + FRAC_W;
  localparam int EXT_W = IN_W + 1;
  localparam int SH    = FRAC_W - OUT_FRAC;
  localparam int AW    = $clog2(DEPTH);
  localparam int WW    = OUT_W + 2;

  localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) << (SH - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [OUT_W-1:0]        MAX_WORD = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [AW:0]             FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]             IF_MAX   = (AW+1)'(2*DEPTH - 1);

  // Round half toward +inf: add half an output LSB, then floor via arithmetic shift.
  // The extra sign bit keeps the addition from overflowing.
  function automatic logic signed [EXT_W-1:0] round_q(input logic [IN_W-1:0] x);
    logic signed [EXT_W-1:0] sum;
    sum = $signed({x[IN_W-1], x}) + HALF;
    return sum >>> SH;
  endfunction

  // Returns {saturated, word}.
  function automatic logic [OUT_W:0] sat_q(input logic signed [EXT_W-1:0] v);
    if (v > SAT_MAX)
      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (v < SAT_MIN)
      return {1'b1, SAT_MIN[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  // ---- stage 1: round and register with the divide-by-zero flag ----
  logic signed [EXT_W-1:0] q_p1;
  logic                    dbz_p1;
  logic                    vld_p1;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) vld_p1 <= 1'b0;
    else        vld_p1 <= axis.s_axis_result_tvalid;
  end

  always_ff @(posedge aclk) begin
    if (axis.s_axis_result_tvalid) begin
      q_p1   <= round_q(axis.s_axis_result_tdata);
      dbz_p1 <= axis.s_axis_result_tuser;
    end
  end

  // ---- stage 2: saturate, form {tuser, data}, write FIFO ----
  logic [OUT_W:0] sat_p2;
  logic [WW-1:0]  word_p2;

  always_comb begin
    sat_p2 = sat_q(q_p1);
    if (dbz_p1) word_p2 = {2'b11, MAX_WORD};
    else        word_p2 = {1'b0, sat_p2[OUT_W], sat_p2[OUT_W-1:0]};
  end

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push, drop;

  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && axis.m_axis_tready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = vld_p1 && (!full || pop);
  assign drop = vld_p1 && full && !pop;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= word_p2;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

  // Output gated by occupancy so the unreset storage never reaches the port.
  logic [WW-1:0] head;
  assign head               = mem[rd_ptr];
  assign axis.m_axis_tvalid = (count != '0);
  assign axis.m_axis_tdata  = axis.m_axis_tvalid ? head[OUT_W-1:0] : '0;
  assign axis.m_axis_tuser  = axis.m_axis_tvalid ? head[WW-1:OUT_W] : 2'b00;

  // Credits: divides launched whose result has not yet been captured.
  logic [AW:0]   in_flight;
  logic [AW+2:0] credit_sum;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_flight <= '0;
    end else if (issue && !axis.s_axis_result_tvalid) begin
      if (in_flight != IF_MAX) in_flight <= in_flight + 1'b1;
    end else if (!issue && axis.s_axis_result_tvalid) begin
      if (in_flight != '0) in_flight <= in_flight - 1'b1;
    end
  end

  // Every in-flight, staged or buffered result owns one FIFO slot.
  assign credit_sum = (AW+3)'(in_flight) + (AW+3)'(vld_p1) + (AW+3)'(count);
  assign issue_ok   = credit_sum < (AW+3)'(DEPTH);

endmodule

// File: tb/tb_divide_result_buffer.sv
// tb_divide_result_buffer
//   Directed and randomized stimulus for divide_result_buffer, checked every cycle
//   against a queue-based reference model of the rounding, FIFO and credit rules.
module tb_divide_result_buffer;
  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        issue;
  logic        issue_ok;
  logic [15:0] overflow_cnt;

  divide_result_buffer_if #(.IN_W(64), .OUT_W(32)) axis_if ();

  divide_result_buffer #(
    .INT_W(40), .FRAC_W(24), .OUT_W(32), .OUT_FRAC(16), .DEPTH(DEPTH)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .issue        (issue),
    .issue_ok     (issue_ok),
    .axis         (axis_if),
    .overflow_cnt (overflow_cnt)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [33:0] mq[$];   // FIFO contents {tuser, data}
  logic        st_v;    // result captured at the last edge, not yet in the FIFO
  logic [33:0] st_w;
  int          in_fl;
  int          ovf_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round half toward +inf to Q16.16, then saturate to signed 32 bits.
  function automatic logic [33:0] ref_word(input logic [63:0] d, input logic dbz);
    longint x, q;
    logic [31:0] w;
    if (dbz) return {2'b11, 32'h7FFFFFFF};
    x = d;
    q = x >>> 8;
    if (d[7]) q = q + 1;
    if (q > 64'sd2147483647)       return {2'b01, 32'h7FFFFFFF};
    if (q < -64'sd2147483648)      return {2'b01, 32'h80000000};
    w = q[31:0];
    return {2'b00, w};
  endfunction

  function automatic logic [63:0] rnd_data();
    longint v;
    case ($urandom_range(0, 3))
      0: v = {$urandom, $urandom};
      1: begin v = $signed($urandom); v = v * 256 + $urandom_range(0, 255); end
      2: v = longint'($urandom_range(0, 511)) - 256;
      default: begin
        v = 64'sd2147483647 + longint'($urandom_range(0, 2)) - 1;
        if ($urandom_range(0, 1) == 1) v = -v - 1;
        v = v * 256 + $urandom_range(0, 255);
      end
    endcase
    return v;
  endfunction

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [63:0] d, input logic u, input logic iss,
                      input logic rdy, input logic ovr, input logic [33:0] ew);
    logic        pop;
    logic [33:0] h;
    axis_if.s_axis_result_tvalid = v;
    axis_if.s_axis_result_tdata  = d;
    axis_if.s_axis_result_tuser  = u;
    axis_if.m_axis_tready        = rdy;
    issue                        = iss;
    @(negedge aclk);
    chk("tvalid", axis_if.m_axis_tvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("tdata", axis_if.m_axis_tdata, h[31:0]);
      chk("tuser", axis_if.m_axis_tuser, h[33:32]);
    end
    chk("issue_ok", issue_ok, (in_fl + int'(st_v) + mq.size()) < DEPTH);
    chk("overflow_cnt", overflow_cnt, ovf_m);
    pop = (mq.size() != 0) && rdy;
    @(posedge aclk);
    if (pop) void'(mq.pop_front());
    if (st_v) begin
      if (mq.size() < DEPTH) mq.push_back(st_w);
      else if (ovf_m < 65535) ovf_m++;
    end
    if (iss && !v && in_fl < 2*DEPTH - 1) in_fl++;
    else if (!iss && v && in_fl > 0) in_fl--;
    st_v = v;
    st_w = ovr ? ew : ref_word(d, u);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'd0, 1'b0, 1'b0, rdy, 1'b0, 34'd0);
  endtask

  task automatic send(input logic [63:0] d, input logic u, input logic rdy);
    step(1'b1, d, u, 1'b0, rdy, 1'b0, 34'd0);
  endtask

  task automatic sendx(input logic [63:0] d, input logic u, input logic [33:0] ew);
    step(1'b1, d, u, 1'b0, 1'b1, 1'b1, ew);
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, release after one edge.
  task automatic do_reset();
    axis_if.s_axis_result_tvalid = 1'b0;
    axis_if.s_axis_result_tdata  = '0;
    axis_if.s_axis_result_tuser  = 1'b0;
    axis_if.m_axis_tready        = 1'b0;
    issue                        = 1'b0;
    areset                       = 1'b1;
    #1;
    chk("rst_tvalid", axis_if.m_axis_tvalid, 0);
    chk("rst_tdata", axis_if.m_axis_tdata, 0);
    chk("rst_tuser", axis_if.m_axis_tuser, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_issue_ok", issue_ok, 1);
    mq.delete();
    st_v  = 1'b0;
    st_w  = '0;
    in_fl = 0;
    ovf_m = 0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Directed rounding / saturation / divide-by-zero vectors
    sendx(64'h0000000001800000, 1'b0, {2'b00, 32'h00018000});
    sendx(64'h0000000000000080, 1'b0, {2'b00, 32'h00000001});
    sendx(64'hFFFFFFFFFFFFFF80, 1'b0, {2'b00, 32'h00000000});
    sendx(64'hFFFFFFFFFE800000, 1'b0, {2'b00, 32'hFFFE8000});
    sendx(64'h0000010000000000, 1'b0, {2'b01, 32'h7FFFFFFF});
    sendx(64'hFFFFFEFFFF000000, 1'b0, {2'b01, 32'h80000000});
    sendx({$urandom, $urandom}, 1'b1, {2'b11, 32'h7FFFFFFF});
    sendx(64'h0000000000000000, 1'b1, {2'b11, 32'h7FFFFFFF});
    repeat (4) idle(1'b1);

    // Fill the credit window, force one extra result, then drain
    do_reset();
    repeat (DEPTH) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 34'd0);
    chk("issue_ok_after_16", issue_ok, 0);
    repeat (DEPTH + 1) send(rnd_data(), 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    chk("ovf_after_17", overflow_cnt, 1);
    repeat (DEPTH + 2) idle(1'b1);
    chk("issue_ok_drained", issue_ok, 1);
    chk("tvalid_drained", axis_if.m_axis_tvalid, 0);

    // Reset with 5 buffered words and 3 results in flight
    do_reset();
    repeat (8) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 34'd0);
    repeat (5) send(rnd_data(), 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    chk("five_buffered_tvalid", axis_if.m_axis_tvalid, 1);
    do_reset();
    repeat (3) send(rnd_data(), 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    // in_flight must have stayed at 0: 3 buffered + 13 issues reaches the limit exactly
    repeat (DEPTH - 4) step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 34'd0);
    chk("issue_ok_before_13th", issue_ok, 1);
    step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 34'd0);
    chk("issue_ok_after_13th", issue_ok, 0);
    repeat (DEPTH + 2) idle(1'b1);

    // Randomized traffic, including protocol-violating issues and overflow
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, rnd_data(), $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0, 34'd0);
    end
    repeat (DEPTH + 4) idle(1'b1);
    chk("final_empty", axis_if.m_axis_tvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
